// File: rtl/am_similarity_engine_if.sv
// Segment-in / result-out bundle for am_similarity_engine.
//   seg_valid/seg_ready/seg_data      : query segment stream, segment 0 first
//   res_valid/res_ready/res_class/res_score : best-match result
// master: query producer and result consumer. slave: the engine.
interface am_similarity_engine_if #(
  parameter int unsigned DIMS_PER_CC = 64,
  parameter int unsigned CLS_W       = 5,
  parameter int unsigned SCORE_W     = 10
);
  logic                   seg_valid;
  logic                   seg_ready;
  logic [DIMS_PER_CC-1:0] seg_data;
  logic                   res_valid;
  logic                   res_ready;
  logic [CLS_W-1:0]       res_class;
  logic [SCORE_W-1:0]     res_score;

  modport master (
    output seg_valid, seg_data, res_ready,
    input  seg_ready, res_valid, res_class, res_score
  );

  modport slave (
    input  seg_valid, seg_data, res_ready,
    output seg_ready, res_valid, res_class, res_score
  );
endinterface

// File: rtl/am_similarity_engine.sv
// Associative-memory search engine for the sparse HDC classifier.
// A query HV arrives one DIMS_PER_CC segment per handshake; each segment is ANDed with the
// matching segment of every class HV and the popcounts are accumulated per class. After the
// last segment a sequential argmax (one class per cycle, lowest index wins ties) produces the
// best class and its overlap score on the result port.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous abort of the query in progress (beats any handshake)
//   class_hvs  : flattened class HVs, class c segment s at [(c*SEQ+s)*DIMS +: DIMS]
//   busy       : high while the argmax runs or a result is pending
//   am_if      : segment stream in, result out (slave side)
module am_similarity_engine #(
  parameter int unsigned NUM_CLASSES     = 26,
  parameter int unsigned DIMS_PER_CC     = 64,
  parameter int unsigned SEQ_CYCLE_COUNT = 10,
  parameter int unsigned CLS_W           = $clog2(NUM_CLASSES),
  parameter int unsigned SCORE_W         = $clog2(DIMS_PER_CC * SEQ_CYCLE_COUNT + 1)
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              clear,
  input  logic [NUM_CLASSES*SEQ_CYCLE_COUNT*DIMS_PER_CC-1:0] class_hvs,
  output logic                                              busy,
  am_similarity_engine_if.slave                             am_if
);

  localparam int unsigned SegW    = (SEQ_CYCLE_COUNT > 1) ? $clog2(SEQ_CYCLE_COUNT) : 1;
  // One count past the last class: that extra step is the cycle that enters DONE.
  localparam int unsigned ClsCtrW = $clog2(NUM_CLASSES + 1);
  localparam logic [SegW-1:0]    SegLast = SegW'(SEQ_CYCLE_COUNT - 1);
  localparam logic [ClsCtrW-1:0] ClsEnd  = ClsCtrW'(NUM_CLASSES);

  typedef enum logic [1:0] {StAccum, StArgmax, StDone} state_e;

  state_e               state_q, state_d;
  logic [SegW-1:0]      seg_ctr_q, seg_ctr_d;
  logic [ClsCtrW-1:0]   cls_ctr_q, cls_ctr_d;
  logic [SCORE_W-1:0]   acc_q [NUM_CLASSES];
  logic [SCORE_W-1:0]   acc_d [NUM_CLASSES];
  logic [CLS_W-1:0]     best_idx_q, best_idx_d;
  logic [SCORE_W-1:0]   best_score_q, best_score_d;

  logic [SCORE_W-1:0]   ov [NUM_CLASSES];
  logic [SCORE_W-1:0]   cur_score;
  logic                 seg_hs;

  function automatic logic [SCORE_W-1:0] popcnt(input logic [DIMS_PER_CC-1:0] v);
    logic [SCORE_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(DIMS_PER_CC); i++) begin
      cnt = cnt + SCORE_W'(v[i]);
    end
    return cnt;
  endfunction

  assign am_if.seg_ready = (state_q == StAccum);
  assign am_if.res_valid = (state_q == StDone);
  assign am_if.res_class = best_idx_q;
  assign am_if.res_score = best_score_q;
  assign busy            = (state_q != StAccum);

  // A segment offered in a clear cycle is dropped even though seg_ready is high.
  assign seg_hs = am_if.seg_valid & am_if.seg_ready & ~clear;

  always_comb begin
    for (int c = 0; c < int'(NUM_CLASSES); c++) begin
      ov[c] = popcnt(class_hvs[(c * int'(SEQ_CYCLE_COUNT) + int'(seg_ctr_q)) * int'(DIMS_PER_CC)
                               +: DIMS_PER_CC] & am_if.seg_data);
    end
  end

  always_comb begin
    cur_score = '0;
    if (cls_ctr_q < ClsEnd) begin
      cur_score = acc_q[cls_ctr_q[CLS_W-1:0]];
    end
  end

  always_comb begin
    state_d      = state_q;
    seg_ctr_d    = seg_ctr_q;
    cls_ctr_d    = cls_ctr_q;
    acc_d        = acc_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;

    unique case (state_q)
      StAccum: begin
        if (seg_hs) begin
          for (int c = 0; c < int'(NUM_CLASSES); c++) begin
            // Segment 0 overwrites, so stale scores from an aborted query never leak in.
            acc_d[c] = (seg_ctr_q == '0) ? ov[c] : acc_q[c] + ov[c];
          end
          if (seg_ctr_q == SegLast) begin
            seg_ctr_d = '0;
            cls_ctr_d = '0;
            state_d   = StArgmax;
          end else begin
            seg_ctr_d = seg_ctr_q + 1'b1;
          end
        end
      end
      StArgmax: begin
        if (cls_ctr_q == ClsEnd) begin
          state_d = StDone;
        end else begin
          if (cls_ctr_q == '0) begin
            best_idx_d   = '0;
            best_score_d = cur_score;
          end else if (cur_score > best_score_q) begin
            best_idx_d   = cls_ctr_q[CLS_W-1:0];
            best_score_d = cur_score;
          end
          cls_ctr_d = cls_ctr_q + 1'b1;
        end
      end
      StDone: begin
        if (am_if.res_ready) begin
          state_d = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase

    if (clear) begin
      state_d   = StAccum;
      seg_ctr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StAccum;
      seg_ctr_q    <= '0;
      cls_ctr_q    <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      for (int c = 0; c < int'(NUM_CLASSES); c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      state_q      <= state_d;
      seg_ctr_q    <= seg_ctr_d;
      cls_ctr_q    <= cls_ctr_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      acc_q        <= acc_d;
    end
  end

endmodule

// File: tb/tb_am_similarity_engine.sv
// Randomized self-checking bench for am_similarity_engine; expected results come from a
// whole-HV overlap model ($countones over full 640-bit vectors, first-maximum argmax).
module tb_am_similarity_engine;

  localparam int unsigned NC  = 26;
  localparam int unsigned D   = 64;
  localparam int unsigned S   = 10;
  localparam int unsigned CW  = 5;
  localparam int unsigned SW  = 10;
  localparam int unsigned HvW = D * S;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic [NC*HvW-1:0] class_hvs;
  logic              busy;
  logic [HvW-1:0]    chv [NC];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  am_similarity_engine_if #(.DIMS_PER_CC(D), .CLS_W(CW), .SCORE_W(SW)) am_if ();

  am_similarity_engine #(
    .NUM_CLASSES(NC), .DIMS_PER_CC(D), .SEQ_CYCLE_COUNT(S), .CLS_W(CW), .SCORE_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .class_hvs(class_hvs), .busy(busy), .am_if(am_if)
  );

  task automatic pack_classes();
    for (int c = 0; c < int'(NC); c++) class_hvs[c*HvW +: HvW] = chv[c];
  endtask

  function automatic logic [HvW-1:0] rand_hv();
    logic [HvW-1:0] v;
    for (int w = 0; w < int'(HvW / 32); w++) v[w*32 +: 32] = $urandom() & $urandom();
    return v;
  endfunction

  function automatic logic [HvW-1:0] make_hv(input int k);
    logic [HvW-1:0] v;
    v = '0;
    while ($countones(v) < k) v[$urandom_range(0, HvW - 1)] = 1'b1;
    return v;
  endfunction

  task automatic rand_classes();
    for (int c = 0; c < int'(NC); c++) chv[c] = rand_hv();
    pack_classes();
  endtask

  // Reference: overlap of whole HVs, strict '>' keeps the lowest index on ties.
  task automatic model(input logic [HvW-1:0] q, output int cls, output int sc);
    int ov;
    sc = -1;
    cls = 0;
    for (int c = 0; c < int'(NC); c++) begin
      ov = $countones(chv[c] & q);
      if (ov > sc) begin
        sc = ov;
        cls = c;
      end
    end
  endtask

  // Drives segments first..last starting at a negedge; returns at the negedge after the
  // last handshake. ok=0 if the engine never became ready.
  task automatic send_query(input logic [HvW-1:0] qv, input int first, input int last,
                            input int gap_max, output bit ok);
    int g, t;
    ok = 1'b1;
    for (int s = first; s <= last; s++) begin
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      am_if.seg_valid = 1'b0;
      repeat (g) @(negedge clk);
      am_if.seg_valid = 1'b1;
      am_if.seg_data  = qv[s*D +: D];
      t = 0;
      while (!am_if.seg_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    am_if.seg_valid = 1'b0;
  endtask

  // Counts edges after the last handshake until res_valid is seen (bounded).
  task automatic wait_result(output int cyc, output bit busy_ok);
    cyc = 0;
    busy_ok = 1'b1;
    while (!am_if.res_valid && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic consume();
    am_if.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    am_if.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit ok, bok;
    int cyc;
    bit seen;
    // Power-on values while rst_n is still low.
    total++; if (am_if.seg_ready !== 1'b1) begin bad++; $display("FAIL por_seg_ready got=%b exp=1", am_if.seg_ready); end
    total++; if (am_if.res_valid !== 1'b0) begin bad++; $display("FAIL por_res_valid got=%b exp=0", am_if.res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL por_busy got=%b exp=0", busy); end
    @(negedge clk) rst_n = 1'b1;
    // Reset while a result (class 7) is pending and a new segment is being offered.
    for (int c = 0; c < int'(NC); c++) chv[c] = '0;
    chv[7] = '1;
    pack_classes();
    send_query('1, 0, S - 1, 0, ok);
    wait_result(cyc, bok);
    am_if.seg_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++; if (am_if.seg_ready !== 1'b1) begin bad++; $display("FAIL rst_seg_ready got=%b exp=1", am_if.seg_ready); end
    total++; if (am_if.res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b exp=0", am_if.res_valid); end
    total++; if (am_if.res_class !== 5'd0) begin bad++; $display("FAIL rst_res_class got=%0d exp=0", am_if.res_class); end
    total++; if (am_if.res_score !== 10'd0) begin bad++; $display("FAIL rst_res_score got=%0d exp=0", am_if.res_score); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    am_if.seg_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    // Reset mid-argmax: no result may appear afterwards.
    send_query('1, 0, S - 1, 0, ok);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_argmax_busy got=%b exp=0", busy); end
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (am_if.res_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_argmax_no_result got=%b exp=0", seen); end
  endtask

  task automatic test_onehot();
    bit ok, bok;
    int cyc;
    for (int c = 0; c < int'(NC); c++) chv[c] = '0;
    chv[7] = '1;
    pack_classes();
    send_query('1, 0, S - 1, 0, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL onehot_accept got=%b exp=1", ok); end
    wait_result(cyc, bok);
    total++; if (cyc !== 27) begin bad++; $display("FAIL onehot_latency got=%0d exp=27", cyc); end
    total++; if (bok !== 1'b1) begin bad++; $display("FAIL onehot_busy_during got=%b exp=1", bok); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL onehot_busy_done got=%b exp=1", busy); end
    total++; if (int'(am_if.res_class) !== 7) begin bad++; $display("FAIL onehot_class got=%0d exp=7", am_if.res_class); end
    total++; if (int'(am_if.res_score) !== 640) begin bad++; $display("FAIL onehot_score got=%0d exp=640", am_if.res_score); end
    consume();
    total++; if (am_if.res_valid !== 1'b0) begin bad++; $display("FAIL onehot_consumed got=%b exp=0", am_if.res_valid); end
  endtask

  task automatic test_tie();
    bit ok, bok;
    int cyc;
    chv[3] = make_hv(100);
    for (int c = 0; c < int'(NC); c++) if (c != 3) chv[c] = make_hv($urandom_range(0, 99));
    chv[12] = chv[3];
    pack_classes();
    send_query('1, 0, S - 1, 2, ok);
    wait_result(cyc, bok);
    total++; if (int'(am_if.res_class) !== 3) begin bad++; $display("FAIL tie_class got=%0d exp=3", am_if.res_class); end
    total++; if (int'(am_if.res_score) !== 100) begin bad++; $display("FAIL tie_score got=%0d exp=100", am_if.res_score); end
    consume();
  endtask

  task automatic test_random();
    bit ok, bok;
    int cyc, ecls, esc;
    logic [HvW-1:0] q;
    rand_classes();
    send_query('0, 0, S - 1, 1, ok);
    wait_result(cyc, bok);
    total++; if (int'(am_if.res_class) !== 0) begin bad++; $display("FAIL zero_class got=%0d exp=0", am_if.res_class); end
    total++; if (int'(am_if.res_score) !== 0) begin bad++; $display("FAIL zero_score got=%0d exp=0", am_if.res_score); end
    consume();
    for (int n = 0; n < 6; n++) begin
      rand_classes();
      for (int w = 0; w < int'(HvW / 32); w++) q[w*32 +: 32] = $urandom();
      model(q, ecls, esc);
      send_query(q, 0, S - 1, 3, ok);
      wait_result(cyc, bok);
      total++; if (int'(am_if.res_class) !== ecls) begin bad++; $display("FAIL rand_class[%0d] got=%0d exp=%0d", n, am_if.res_class, ecls); end
      total++; if (int'(am_if.res_score) !== esc) begin bad++; $display("FAIL rand_score[%0d] got=%0d exp=%0d", n, am_if.res_score, esc); end
      consume();
    end
  endtask

  task automatic test_hold();
    bit ok, bok, v_ok, c_ok, s_ok, r_ok;
    int cyc, ecls, esc, ecls2, esc2;
    logic [HvW-1:0] q, q2;
    rand_classes();
    for (int w = 0; w < int'(HvW / 32); w++) q[w*32 +: 32] = $urandom();
    for (int w = 0; w < int'(HvW / 32); w++) q2[w*32 +: 32] = $urandom();
    model(q, ecls, esc);
    model(q2, ecls2, esc2);
    send_query(q, 0, S - 1, 0, ok);
    wait_result(cyc, bok);
    v_ok = 1'b1; c_ok = 1'b1; s_ok = 1'b1; r_ok = 1'b1;
    am_if.seg_valid = 1'b1;
    am_if.seg_data  = q2[0 +: D];
    repeat (5) begin
      if (am_if.res_valid !== 1'b1) v_ok = 1'b0;
      if (int'(am_if.res_class) !== ecls) c_ok = 1'b0;
      if (int'(am_if.res_score) !== esc) s_ok = 1'b0;
      if (am_if.seg_ready !== 1'b0) r_ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    total++; if (v_ok !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b exp=1", v_ok); end
    total++; if (c_ok !== 1'b1) begin bad++; $display("FAIL hold_class got=%0d exp=%0d", am_if.res_class, ecls); end
    total++; if (s_ok !== 1'b1) begin bad++; $display("FAIL hold_score got=%0d exp=%0d", am_if.res_score, esc); end
    total++; if (r_ok !== 1'b1) begin bad++; $display("FAIL hold_seg_ready_low got=%b exp=1", r_ok); end
    am_if.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    am_if.res_ready = 1'b0;
    total++; if (am_if.seg_ready !== 1'b1) begin bad++; $display("FAIL hold_ready_after got=%b exp=1", am_if.seg_ready); end
    total++; if (am_if.res_valid !== 1'b0) begin bad++; $display("FAIL hold_valid_after got=%b exp=0", am_if.res_valid); end
    // seg_valid still high with segment 0 of q2: taken on this edge.
    @(posedge clk);
    @(negedge clk);
    send_query(q2, 1, S - 1, 0, ok);
    wait_result(cyc, bok);
    total++; if (int'(am_if.res_class) !== ecls2) begin bad++; $display("FAIL hold_next_class got=%0d exp=%0d", am_if.res_class, ecls2); end
    total++; if (int'(am_if.res_score) !== esc2) begin bad++; $display("FAIL hold_next_score got=%0d exp=%0d", am_if.res_score, esc2); end
    consume();
  endtask

  task automatic test_clear();
    bit ok, bok, seen;
    int cyc, ecls, esc;
    logic [HvW-1:0] qa, qb;
    rand_classes();
    for (int w = 0; w < int'(HvW / 32); w++) qa[w*32 +: 32] = $urandom();
    for (int w = 0; w < int'(HvW / 32); w++) qb[w*32 +: 32] = $urandom();
    // Abort after 4 segments, then a full new query.
    send_query(qa, 0, 3, 1, ok);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    model(qb, ecls, esc);
    send_query(qb, 0, S - 1, 1, ok);
    wait_result(cyc, bok);
    total++; if (int'(am_if.res_class) !== ecls) begin bad++; $display("FAIL clr_mid_class got=%0d exp=%0d", am_if.res_class, ecls); end
    total++; if (int'(am_if.res_score) !== esc) begin bad++; $display("FAIL clr_mid_score got=%0d exp=%0d", am_if.res_score, esc); end
    consume();
    // Abort during argmax.
    send_query(qa, 0, S - 1, 0, ok);
    repeat (5) @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_argmax_busy got=%b exp=0", busy); end
    total++; if (am_if.seg_ready !== 1'b1) begin bad++; $display("FAIL clr_argmax_ready got=%b exp=1", am_if.seg_ready); end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (am_if.res_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL clr_argmax_no_result got=%b exp=0", seen); end
    // Segment offered together with clear must be ignored.
    am_if.seg_valid = 1'b1;
    am_if.seg_data  = qa[0 +: D];
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    am_if.seg_valid = 1'b0;
    model(qb, ecls, esc);
    send_query(qb, 0, S - 1, 0, ok);
    wait_result(cyc, bok);
    total++; if (cyc !== 27) begin bad++; $display("FAIL clr_seg_latency got=%0d exp=27", cyc); end
    total++; if (int'(am_if.res_class) !== ecls) begin bad++; $display("FAIL clr_seg_class got=%0d exp=%0d", am_if.res_class, ecls); end
    total++; if (int'(am_if.res_score) !== esc) begin bad++; $display("FAIL clr_seg_score got=%0d exp=%0d", am_if.res_score, esc); end
    consume();
  endtask

  initial begin
    am_if.seg_valid = 1'b0;
    am_if.seg_data  = '0;
    am_if.res_ready = 1'b0;
    for (int c = 0; c < int'(NC); c++) chv[c] = '0;
    pack_classes();
    repeat (2) @(negedge clk);
    test_reset();
    test_onehot();
    test_tie();
    test_random();
    test_hold();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
